// File: rtl/mem_wrapper_pipe.sv
`default_nettype none
// mem_wrapper_pipe: inferred simple dual-port RAM, 1- or 2-cycle read pipeline, optional
// write-to-read forwarding; parity storage/check enabled by MEM_WRAPPER_PIPE_PARITY_EN.
module mem_wrapper_pipe #(
    parameter int  DW     = 64,
    parameter int  DEPTH  = 512,
    parameter int  RD_LAT = 2,
    parameter int  BYPASS = 1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wren,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          rden,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata,
    output logic          rdata_vld,
    output logic          addr_err,
    output logic          par_err,
    output logic          par_err_sticky
);

`ifdef MEM_WRAPPER_PIPE_PARITY_EN
    localparam int MW = DW + 1;
`else
    localparam int MW = DW;
`endif
    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    logic [MW-1:0] mem_q [DEPTH];
    logic [MW-1:0] wentry;
    logic          wr_ok;
    logic          rd_inr;
    logic          fwd;
    logic [MW-1:0] dat1_d;
    logic [MW-1:0] dat1_q;
    logic          vld1_q;
    logic          aerr1_q;

`ifdef MEM_WRAPPER_PIPE_PARITY_EN
    assign wentry = {^wdata, wdata};
`else
    assign wentry = wdata;
`endif

    assign wr_ok  = wren && !rst && ({1'b0, waddr} < c_DEPTH);
    assign rd_inr = ({1'b0, raddr} < c_DEPTH);
    assign fwd    = (BYPASS != 0) && wr_ok && (waddr == raddr);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[waddr] <= wentry;
        end
    end

    // Out-of-range reads return zeros; forwarding substitutes the word being written.
    always_comb begin
        dat1_d = '0;
        if (rd_inr) begin
            dat1_d = fwd ? wentry : mem_q[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld1_q  <= 1'b0;
            aerr1_q <= 1'b0;
            dat1_q  <= '0;
        end else begin
            vld1_q <= rden;
            if (rden) begin
                aerr1_q <= !rd_inr;
                dat1_q  <= dat1_d;
            end
        end
    end

`ifdef MEM_WRAPPER_PIPE_PARITY_EN
    logic perr1;
    logic par_pulse;
    logic sticky_q;

    assign perr1 = vld1_q && !aerr1_q && (dat1_q[DW] != ^dat1_q[DW-1:0]);
`endif

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DW-1:0] dat2_q;
            logic          vld2_q;
            logic          aerr2_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld2_q  <= 1'b0;
                    aerr2_q <= 1'b0;
                    dat2_q  <= '0;
                end else begin
                    vld2_q  <= vld1_q;
                    aerr2_q <= vld1_q & aerr1_q;
                    if (vld1_q) begin
                        dat2_q <= dat1_q[DW-1:0];
                    end
                end
            end

            assign rdata     = dat2_q;
            assign rdata_vld = vld2_q;
            assign addr_err  = aerr2_q;
`ifdef MEM_WRAPPER_PIPE_PARITY_EN
            logic perr2_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    perr2_q <= 1'b0;
                end else begin
                    perr2_q <= perr1;
                end
            end
            assign par_pulse = perr2_q;
`endif
        end else begin : g_lat1
            assign rdata     = dat1_q[DW-1:0];
            assign rdata_vld = vld1_q;
            assign addr_err  = vld1_q & aerr1_q;
`ifdef MEM_WRAPPER_PIPE_PARITY_EN
            assign par_pulse = perr1;
`endif
        end
    endgenerate

`ifdef MEM_WRAPPER_PIPE_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else if (par_pulse) begin
            sticky_q <= 1'b1;
        end
    end

    assign par_err        = par_pulse;
    assign par_err_sticky = sticky_q;
`else
    assign par_err        = 1'b0;
    assign par_err_sticky = 1'b0;
`endif

endmodule
`default_nettype wire
